rs_dual_issue_scheduler: RTL and testbench

//  Per-cycle issue scheduler for a reservation station (RS): picks up to two ready RS entries and

---
 rtl/rs_sched_pkg.sv | 15 +
 rtl/priority_selector.sv | 12 +
 rtl/rs_rotate_select.sv | 46 ++++
 rtl/rs_dual_issue_scheduler.sv | 101 ++++++++++
 tb/tb_rs_dual_issue_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rs_sched_pkg.sv
// rtl/rs_sched_pkg.sv - shared types and constants for the RS dual-issue scheduler
package rs_sched_pkg;

    localparam int ISSUE_WIDTH     = 2;
    localparam int RS_SIZE_DEFAULT = 8;
    localparam int IDX_W_DEFAULT   = $clog2(RS_SIZE_DEFAULT);

    typedef logic [IDX_W_DEFAULT-1:0] rs_idx_t;

    typedef struct packed {
        logic    valid;
        rs_idx_t idx;
    } issue_slot_t;

endpackage

// File: rtl/priority_selector.sv
// rtl/priority_selector.sv - one-hot grant of the lowest set request bit
module priority_selector #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + WIDTH'(1));

endmodule

// File: rtl/rs_rotate_select.sv
// rtl/rs_rotate_select.sv - rotating two-winner picker over RS ready bits
module rs_rotate_select #(
    parameter int RS_SIZE = 8,
    parameter int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [RS_SIZE-1:0] gnt_a,
    output logic [RS_SIZE-1:0] gnt_b
);

    logic [RS_SIZE-1:0] rot_req;
    logic [RS_SIZE-1:0] rot_a;
    logic [RS_SIZE-1:0] rot_b;
    logic [RS_SIZE-1:0] rot_req_b;

    // Entry ptr lands on bit 0; index arithmetic wraps since RS_SIZE is a power of two.
    always_comb begin
        rot_req = '0;
        for (int j = 0; j < RS_SIZE; j++) begin
            rot_req[j] = req[IDX_W'(j) + ptr];
        end
    end

    assign rot_req_b = rot_req & ~rot_a;

    priority_selector #(.WIDTH(RS_SIZE)) u_sel_a (
        .req (rot_req),
        .gnt (rot_a)
    );

    priority_selector #(.WIDTH(RS_SIZE)) u_sel_b (
        .req (rot_req_b),
        .gnt (rot_b)
    );

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int j = 0; j < RS_SIZE; j++) begin
            gnt_a[IDX_W'(j) + ptr] = rot_a[j];
            gnt_b[IDX_W'(j) + ptr] = rot_b[j];
        end
    end

endmodule

// File: rtl/rs_dual_issue_scheduler.sv
// rtl/rs_dual_issue_scheduler.sv - picks up to two ready RS entries into two FU issue slots
module rs_dual_issue_scheduler
    import rs_sched_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEFAULT,
    parameter int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [RS_SIZE-1:0]     entry_ready,
    input  logic [ISSUE_WIDTH-1:0] fu_stall,
    output logic [RS_SIZE-1:0]     issue_mask,
    output logic [ISSUE_WIDTH-1:0] issue_valid,
    output logic [IDX_W-1:0]       issue_idx0,
    output logic [IDX_W-1:0]       issue_idx1,
    output logic [IDX_W-1:0]       rr_ptr
);

    logic [RS_SIZE-1:0]     pick_a;
    logic [RS_SIZE-1:0]     pick_b;
    logic [RS_SIZE-1:0]     gnt0;
    logic [RS_SIZE-1:0]     gnt1;
    logic [ISSUE_WIDTH-1:0] acc;
    logic [IDX_W-1:0]       gidx0;
    logic [IDX_W-1:0]       gidx1;
    logic [IDX_W-1:0]       last_idx;
    logic                   any_gnt;

    rs_rotate_select #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) u_select (
        .req   (entry_ready),
        .ptr   (rr_ptr),
        .gnt_a (pick_a),
        .gnt_b (pick_b)
    );

    assign acc = ~issue_valid | ~fu_stall;

    // With only one accepting slot, the first pick goes wherever there is room.
    always_comb begin
        gnt0 = '0;
        gnt1 = '0;
        if (!reset && !flush) begin
            case (acc)
                2'b11: begin
                    gnt0 = pick_a;
                    gnt1 = pick_b;
                end
                2'b01: gnt0 = pick_a;
                2'b10: gnt1 = pick_a;
                default: ;
            endcase
        end
    end

    assign issue_mask = gnt0 | gnt1;
    assign any_gnt    = |issue_mask;

    always_comb begin
        gidx0 = '0;
        gidx1 = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (gnt0[i]) gidx0 = IDX_W'(i);
            if (gnt1[i]) gidx1 = IDX_W'(i);
        end
    end

    // Slot 1 is granted only when it carries the latest pick.
    assign last_idx = (|gnt1) ? gidx1 : gidx0;

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid <= '0;
            issue_idx0  <= '0;
            issue_idx1  <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            issue_valid <= '0;
            rr_ptr      <= '0;
        end else begin
            if (|gnt0) begin
                issue_valid[0] <= 1'b1;
                issue_idx0     <= gidx0;
            end else if (!(issue_valid[0] && fu_stall[0])) begin
                issue_valid[0] <= 1'b0;
            end

            if (|gnt1) begin
                issue_valid[1] <= 1'b1;
                issue_idx1     <= gidx1;
            end else if (!(issue_valid[1] && fu_stall[1])) begin
                issue_valid[1] <= 1'b0;
            end

            if (any_gnt) begin
                rr_ptr <= last_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rs_dual_issue_scheduler.sv
// tb/tb_rs_dual_issue_scheduler.sv - self-checking bench for rs_dual_issue_scheduler
module tb_rs_dual_issue_scheduler;

    logic       clock;
    logic       reset;
    logic       flush;
    logic [7:0] entry_ready;
    logic [1:0] fu_stall;
    logic [7:0] issue_mask;
    logic [1:0] issue_valid;
    logic [2:0] issue_idx0;
    logic [2:0] issue_idx1;
    logic [2:0] rr_ptr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] ready;
        logic [1:0] stall;
        logic       fl;
        logic [7:0] mask;
        logic [1:0] valid;
        logic [2:0] idx0;
        logic [2:0] idx1;
        logic [2:0] ptr;
        logic       chk_idx;
    } vec_t;

    typedef struct {
        logic [1:0] valid;
        logic [2:0] idx0;
        logic [2:0] idx1;
        logic [2:0] ptr;
        logic       chk0;
        logic       chk1;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    logic [1:0] m_valid;
    logic [2:0] m_idx0;
    logic [2:0] m_idx1;
    logic [2:0] m_ptr;

    rs_dual_issue_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .entry_ready (entry_ready),
        .fu_stall    (fu_stall),
        .issue_mask  (issue_mask),
        .issue_valid (issue_valid),
        .issue_idx0  (issue_idx0),
        .issue_idx1  (issue_idx1),
        .rr_ptr      (rr_ptr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input logic [7:0] rdy, input logic [1:0] stl, input logic fl,
                        input logic [7:0] em, input exp_t e, input string tag);
        exp_t got;
        @(negedge clock);
        entry_ready = rdy;
        fu_stall    = stl;
        flush       = fl;
        #1;
        chk({tag, "_mask"}, int'(issue_mask), int'(em));
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            got = sb.pop_front();
            chk({tag, "_valid"}, int'(issue_valid), int'(got.valid));
            chk({tag, "_ptr"}, int'(rr_ptr), int'(got.ptr));
            if (got.chk0) chk({tag, "_idx0"}, int'(issue_idx0), int'(got.idx0));
            if (got.chk1) chk({tag, "_idx1"}, int'(issue_idx1), int'(got.idx1));
        end
    endtask

    // Independent scan-based reference for the random phase.
    task automatic model(input logic [7:0] rdy, input logic [1:0] stl, input logic fl,
                         output logic [7:0] em, output exp_t e);
        int a = -1;
        int b = -1;
        int s0 = -1;
        int s1 = -1;
        logic [1:0] acc;
        for (int j = 0; j < 8; j++) begin
            int k = (int'(m_ptr) + j) % 8;
            if (rdy[k]) begin
                if (a < 0) a = k;
                else if (b < 0) b = k;
            end
        end
        acc = ~m_valid | ~stl;
        if (!fl) begin
            if (acc == 2'b11) begin s0 = a; s1 = b; end
            else if (acc == 2'b01) s0 = a;
            else if (acc == 2'b10) s1 = a;
        end
        em = 8'h00;
        if (s0 >= 0) em[s0] = 1'b1;
        if (s1 >= 0) em[s1] = 1'b1;
        if (fl) begin
            m_valid = 2'b00;
            m_ptr   = 3'd0;
        end else begin
            if (s0 >= 0) begin m_valid[0] = 1'b1; m_idx0 = 3'(s0); end
            else if (!(m_valid[0] && stl[0])) m_valid[0] = 1'b0;
            if (s1 >= 0) begin m_valid[1] = 1'b1; m_idx1 = 3'(s1); end
            else if (!(m_valid[1] && stl[1])) m_valid[1] = 1'b0;
            if (s1 >= 0) m_ptr = 3'((s1 + 1) % 8);
            else if (s0 >= 0) m_ptr = 3'((s0 + 1) % 8);
        end
        e.valid = m_valid;
        e.idx0  = m_idx0;
        e.idx1  = m_idx1;
        e.ptr   = m_ptr;
        e.chk0  = m_valid[0];
        e.chk1  = m_valid[1];
    endtask

    initial begin
        exp_t       e;
        logic [7:0] em;
        logic [7:0] rdy;
        logic [1:0] stl;
        logic       fl;

        //          ready  stall fl  mask   valid  idx0  idx1  ptr  chk_idx
        vecs[0]  = '{8'h06, 2'b00, 0, 8'h06, 2'b11, 3'd1, 3'd2, 3'd3, 1};
        vecs[1]  = '{8'hFF, 2'b00, 0, 8'h18, 2'b11, 3'd3, 3'd4, 3'd5, 1};
        vecs[2]  = '{8'h40, 2'b00, 0, 8'h40, 2'b01, 3'd6, 3'd4, 3'd7, 1};
        vecs[3]  = '{8'h81, 2'b00, 0, 8'h81, 2'b11, 3'd7, 3'd0, 3'd1, 1};
        vecs[4]  = '{8'h20, 2'b00, 0, 8'h20, 2'b01, 3'd5, 3'd0, 3'd6, 1};
        vecs[5]  = '{8'h01, 2'b01, 0, 8'h01, 2'b11, 3'd5, 3'd0, 3'd1, 1};
        vecs[6]  = '{8'h0F, 2'b11, 0, 8'h00, 2'b11, 3'd5, 3'd0, 3'd1, 1};
        vecs[7]  = '{8'h0F, 2'b11, 1, 8'h00, 2'b00, 3'd0, 3'd0, 3'd0, 0};
        vecs[8]  = '{8'h00, 2'b00, 0, 8'h00, 2'b00, 3'd0, 3'd0, 3'd0, 0};
        vecs[9]  = '{8'h03, 2'b00, 0, 8'h03, 2'b11, 3'd0, 3'd1, 3'd2, 1};
        vecs[10] = '{8'h00, 2'b10, 0, 8'h00, 2'b10, 3'd0, 3'd1, 3'd2, 1};
        vecs[11] = '{8'h0C, 2'b10, 0, 8'h04, 2'b11, 3'd2, 3'd1, 3'd3, 1};
        vecs[12] = '{8'h80, 2'b00, 0, 8'h80, 2'b01, 3'd7, 3'd1, 3'd0, 1};

        reset       = 1'b1;
        flush       = 1'b0;
        entry_ready = 8'hFF;
        fu_stall    = 2'b00;
        @(negedge clock);
        #1;
        chk("reset_mask", int'(issue_mask), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        entry_ready = 8'h00;
        #1;
        chk("reset_valid", int'(issue_valid), 0);
        chk("reset_ptr", int'(rr_ptr), 0);
        chk("reset_idx0", int'(issue_idx0), 0);
        chk("reset_idx1", int'(issue_idx1), 0);

        for (int i = 0; i < 13; i++) begin
            e.valid = vecs[i].valid;
            e.idx0  = vecs[i].idx0;
            e.idx1  = vecs[i].idx1;
            e.ptr   = vecs[i].ptr;
            e.chk0  = vecs[i].chk_idx;
            e.chk1  = vecs[i].chk_idx;
            step(vecs[i].ready, vecs[i].stall, vecs[i].fl, vecs[i].mask, e, $sformatf("vec%0d", i));
        end

        m_valid = issue_valid;
        m_idx0  = vecs[12].idx0;
        m_idx1  = vecs[12].idx1;
        m_ptr   = vecs[12].ptr;
        m_valid = vecs[12].valid;
        for (int n = 0; n < 400; n++) begin
            rdy = 8'($urandom);
            stl = 2'($urandom);
            fl  = ($urandom_range(0, 19) == 0);
            model(rdy, stl, fl, em, e);
            step(rdy, stl, fl, em, e, $sformatf("rnd%0d", n));
        end

        // Reset must win over a simultaneous flush and clear the index registers too.
        @(negedge clock);
        reset       = 1'b1;
        flush       = 1'b1;
        entry_ready = 8'hFF;
        fu_stall    = 2'b00;
        #1;
        chk("rst_flush_mask", int'(issue_mask), 0);
        @(posedge clock);
        #1;
        chk("rst_flush_valid", int'(issue_valid), 0);
        chk("rst_flush_ptr", int'(rr_ptr), 0);
        chk("rst_flush_idx0", int'(issue_idx0), 0);
        chk("rst_flush_idx1", int'(issue_idx1), 0);
        @(negedge clock);
        reset = 1'b0;
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
